// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, bit-counter width and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  localparam int unsigned MAX_DATA_BITS = 9;
  localparam int unsigned BIT_CNT_W     = $clog2(9);

  // Parity bit a transmitter would send for this data word (data zero-extended).
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser with a configurable reset value; shared by the RX data and TX CTS paths.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with run-time parity, framing/parity errors, valid/ready output and sticky overrun.
// Define UART_RX_MAJORITY_EN to vote each bit from the samples at counter 2, 1 and 0.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned BAUD_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [BAUD_W-1:0]    baud,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  logic                 w_rx;
  logic                 w_bit;
  logic                 w_tick;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_start;
  logic                 w_shift;
  logic                 w_par_smp;
  logic                 w_stop_smp;
  logic                 w_done;
  logic                 w_can_load;
  logic                 w_ferr;
  logic                 w_perr;
  uart_rx_state_t       r_state;
  uart_rx_state_t       w_state_nxt;

  logic [BAUD_W-1:0]    r_cnt;
  logic [BAUD_W-1:0]    r_baud;
  logic                 r_par_en;
  logic                 r_par_odd;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;
  logic                 r_busy;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two synchronised samples; at counter 0 these are the counter 2 and 1 samples.
  logic [1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) r_hist <= 2'b11;
    else     r_hist <= {r_hist[0], w_rx};
  end

  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx) | (r_hist[0] & w_rx);
`else
  assign w_bit = w_rx;
`endif

  assign w_tick      = (r_cnt == '0);
  assign w_last_data = (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_state_nxt = START;
      START:   if (w_tick) w_state_nxt = w_bit ? IDLE : DATA;
      DATA:    if (w_tick && w_last_data) w_state_nxt = r_par_en ? PARITY : STOP;
      PARITY:  if (w_tick) w_state_nxt = STOP;
      STOP:    if (w_tick && w_last_stop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    case (r_state)
      IDLE:    w_start    = ~w_rx;
      DATA:    w_shift    = w_tick;
      PARITY:  w_par_smp  = w_tick;
      STOP:    w_stop_smp = w_tick;
      default: ;
    endcase
  end

  assign w_done = w_stop_smp & w_last_stop;

  // Reload with baud-1 so consecutive samples sit exactly baud clocks apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_baud    <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt     <= baud >> 1;
        r_baud    <= baud;
        r_par_en  <= parity_en;
        r_par_odd <= parity_odd;
        r_bit_cnt <= '0;
        r_par_bit <= 1'b0;
        r_ferr    <= 1'b0;
      end else if (r_state != IDLE) begin
        r_cnt <= w_tick ? (r_baud - BAUD_W'(1)) : (r_cnt - BAUD_W'(1));
      end
      if (w_shift) begin
        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= w_last_data ? '0 : (r_bit_cnt + BIT_CNT_W'(1));
      end
      if (w_par_smp) r_par_bit <= w_bit;
      if (w_stop_smp) begin
        if (!w_bit) r_ferr <= 1'b1;
        r_bit_cnt <= w_last_stop ? '0 : (r_bit_cnt + BIT_CNT_W'(1));
      end
    end
  end

  assign w_ferr     = r_ferr | ~w_bit;
  assign w_perr     = r_par_en & (calc_parity(MAX_DATA_BITS'(r_shift), r_par_odd) != r_par_bit);
  assign w_can_load = ~r_valid | rx_ready;

  // Output register: a completion that cannot be accepted is dropped and flags overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_done && w_can_load) begin
        r_data       <= r_shift;
        r_frame_err  <= w_ferr;
        r_parity_err <= w_perr;
        r_valid      <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
      if (w_done && !w_can_load) r_overrun <= 1'b1;
      else if (overrun_clr)      r_overrun <= 1'b0;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8-data/1-stop and a 7-data/2-stop instance fed by a frame generator,
// with a scoreboard queue per instance and hand-written false-start, overrun, reset and glitch sequences.
module tb_uart_rx_param;

  localparam int unsigned BAUD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_a, rx_b;
  logic        rdy_a, rdy_b;
  logic        par_en, par_odd, ovr_clr;
  logic [12:0] baud;

  logic [7:0]  data_a;
  logic        val_a, fe_a, pe_a, ovr_a, busy_a;
  logic [6:0]  data_b;
  logic        val_b, fe_b, pe_b, ovr_b, busy_b;

  int checks   = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    bit         which;
    logic [8:0] data;
    bit         pen;
    bit         podd;
    bit         pflip;
    logic [1:0] stop;
    logic [8:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  vec_t tbl[7];

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .STOP_BITS(1), .BAUD_W(13)) u_dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .baud(baud), .parity_en(par_en), .parity_odd(par_odd),
    .rx_data(data_a), .rx_valid(val_a), .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ovr_a), .overrun_clr(ovr_clr), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2), .BAUD_W(13)) u_dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .baud(baud), .parity_en(par_en), .parity_odd(par_odd),
    .rx_data(data_b), .rx_valid(val_b), .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun(ovr_b), .overrun_clr(ovr_clr), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted word is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!rst && val_a && rdy_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_word: got 0x%0h, expected no word", data_a);
      end else begin
        e_a = q_a.pop_front();
        chk("a_data", 32'(data_a), 32'(e_a.data));
        chk("a_frame_err", 32'(fe_a), 32'(e_a.fe));
        chk("a_parity_err", 32'(pe_a), 32'(e_a.pe));
      end
    end
    if (!rst && val_b && rdy_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_word: got 0x%0h, expected no word", data_b);
      end else begin
        e_b = q_b.pop_front();
        chk("b_data", 32'(data_b), 32'(e_b.data));
        chk("b_frame_err", 32'(fe_b), 32'(e_b.fe));
        chk("b_parity_err", 32'(pe_b), 32'(e_b.pe));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic push_exp(input bit which, input logic [8:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe;
    if (which) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  // Drives one frame; glitch >= 0 inverts rx for that single cycle index of the frame.
  task automatic send_frame(input bit which, input logic [8:0] data, input bit pen, input bit podd,
                            input bit pflip, input logic [1:0] stop, input int glitch);
    logic [15:0] frm;
    logic        p;
    logic        v;
    int          n, nb, ns;
    nb = which ? 7 : 8;
    ns = which ? 2 : 1;
    par_en  = pen;
    par_odd = podd;
    frm = '1;
    n = 0;
    frm[n] = 1'b0; n++;
    p = podd ^ pflip;
    for (int i = 0; i < nb; i++) begin
      frm[n] = data[i]; p = p ^ data[i]; n++;
    end
    if (pen) begin
      frm[n] = p; n++;
    end
    for (int i = 0; i < ns; i++) begin
      frm[n] = stop[i]; n++;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < int'(BAUD); j++) begin
        v = frm[i];
        if (i * int'(BAUD) + j == glitch) v = ~v;
        set_rx(which, v);
        tick(1);
      end
    end
    set_rx(which, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    par_en = 1'b0; par_odd = 1'b0; ovr_clr = 1'b0; baud = 13'(BAUD);

    tbl[0] = '{0, 9'h03C, 1, 0, 0, 2'b11, 9'h03C, 0, 0};
    tbl[1] = '{0, 9'h080, 0, 0, 0, 2'b10, 9'h080, 1, 0};
    tbl[2] = '{0, 9'h000, 1, 1, 1, 2'b11, 9'h000, 0, 1};
    tbl[3] = '{0, 9'h0FF, 1, 1, 0, 2'b11, 9'h0FF, 0, 0};
    tbl[4] = '{1, 9'h055, 1, 1, 1, 2'b11, 9'h055, 0, 1};
    tbl[5] = '{1, 9'h03C, 0, 0, 0, 2'b01, 9'h03C, 1, 0};
    tbl[6] = '{1, 9'h07F, 1, 1, 0, 2'b11, 9'h07F, 0, 0};

    @(posedge clk); #1;
    tick(4);
    chk("rst_a_valid", 32'(val_a), 32'd0);
    chk("rst_a_data", 32'(data_a), 32'd0);
    chk("rst_a_errs", 32'({fe_a, pe_a}), 32'd0);
    chk("rst_a_overrun", 32'(ovr_a), 32'd0);
    chk("rst_a_busy", 32'(busy_a), 32'd0);
    chk("rst_b_valid", 32'(val_b), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    rst = 1'b0;
    tick(4);

    // 8N1 0xA5: rx_valid about 9.5 bit times plus sync latency after the falling edge.
    push_exp(0, 9'h0A5, 0, 0);
    fork
      send_frame(0, 9'h0A5, 0, 0, 0, 2'b11, -1);
      begin
        cyc = 0;
        while (!val_a && cyc < 300) begin
          tick(1);
          cyc++;
        end
      end
    join
    chk("a_latency_in_window", 32'(cyc >= 150 && cyc <= 165), 32'd1);
    tick(2 * BAUD);

    for (int i = 0; i < 7; i++) begin
      push_exp(tbl[i].which, tbl[i].exp_data, tbl[i].exp_fe, tbl[i].exp_pe);
      send_frame(tbl[i].which, tbl[i].data, tbl[i].pen, tbl[i].podd, tbl[i].pflip, tbl[i].stop, -1);
      tick(2 * BAUD);
    end
    chk("table_no_overrun", 32'({ovr_a, ovr_b}), 32'd0);

    // False start: 5-cycle low pulse must be rejected, then a real frame still works.
    par_en = 1'b0;
    set_rx(0, 1'b0);
    tick(5);
    set_rx(0, 1'b1);
    tick(2);
    chk("false_start_busy", 32'(busy_a), 32'd1);
    tick(20);
    chk("false_start_idle", 32'(busy_a), 32'd0);
    chk("false_start_no_valid", 32'(val_a), 32'd0);
    push_exp(0, 9'h081, 0, 0);
    send_frame(0, 9'h081, 0, 0, 0, 2'b11, -1);
    tick(2 * BAUD);

    // Overrun: second back-to-back word is dropped while the first is held.
    rdy_a = 1'b0;
    push_exp(0, 9'h011, 0, 0);
    send_frame(0, 9'h011, 0, 0, 0, 2'b11, -1);
    send_frame(0, 9'h022, 0, 0, 0, 2'b11, -1);
    tick(4);
    chk("ovr_held_valid", 32'(val_a), 32'd1);
    chk("ovr_held_data", 32'(data_a), 32'h11);
    chk("ovr_set", 32'(ovr_a), 32'd1);
    rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    tick(1);
    chk("ovr_valid_cleared", 32'(val_a), 32'd0);
    chk("ovr_sticky", 32'(ovr_a), 32'd1);
    tick(3);
    chk("ovr_still_sticky", 32'(ovr_a), 32'd1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(ovr_a), 32'd0);

    // Reset mid-frame with a word pending discards both.
    send_frame(0, 9'h05A, 0, 0, 0, 2'b11, -1);
    tick(4);
    chk("pending_before_rst", 32'(val_a), 32'd1);
    set_rx(0, 1'b0);
    tick(40);
    chk("busy_mid_frame", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_valid", 32'(val_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    set_rx(0, 1'b1);
    tick(2);
    rst = 1'b0;
    rdy_a = 1'b1;
    tick(2 * BAUD);
    chk("after_rst_idle", 32'(busy_a), 32'd0);
    push_exp(0, 9'h096, 0, 0);
    send_frame(0, 9'h096, 0, 0, 0, 2'b11, -1);
    tick(2 * BAUD);

    // One-cycle glitch exactly on the bit-2 sample point.
`ifdef UART_RX_MAJORITY_EN
    push_exp(0, 9'h0F0, 0, 0);
`else
    push_exp(0, 9'h0F4, 0, 0);
`endif
    send_frame(0, 9'h0F0, 0, 0, 0, 2'b11, 57);
    tick(2 * BAUD);

    cyc = 0;
    while ((q_a.size() + q_b.size()) != 0 && cyc < 100) begin
      tick(1);
      cyc++;
    end
    chk("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    chk("final_overrun", 32'({ovr_a, ovr_b}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
